// File: rtl/stream_data_processor.sv
// Stream data processor: per-word add/sub/xor/pass stage feeding a FIFO that is
// drained one word at a time into a UART transmitter under a tx_busy handshake.
module stream_data_processor #(
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int OP_CONST      = 1,
  parameter int START_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_data_valid,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic [1:0]                    mode,
  input  logic                          tx_busy,
  input  logic                          clr_overflow,
  output logic                          tx_en,
  output logic [DATA_BITS-1:0]          data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [DATA_BITS-1:0] K         = DATA_BITS'(OP_CONST);
  localparam logic [TW-1:0]        TMO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0]        CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  state_e                 state_q;
  logic [TW-1:0]          tmo_q;
  logic                   tx_en_q;
  logic [DATA_BITS-1:0]   data_out_q;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, empty_q, overflow_q;

  logic [DATA_BITS-1:0]   op_result;
  logic                   pop, wr_en, drop;

  // Operation stage; results wrap silently at DATA_BITS.
  always_comb begin
    op_result = rx_data;
    unique case (mode)
      2'b00:   op_result = rx_data + K;
      2'b01:   op_result = rx_data - K;
      2'b10:   op_result = rx_data ^ K;
      default: op_result = rx_data;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign pop   = (state_q == IDLE) && !empty_q && !tx_busy;
  assign wr_en = rx_data_valid && (!full_q || pop);
  assign drop  = rx_data_valid && !wr_en;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_en) count_d = count_q - CW'(1);
  end

  // NOTE: storage carries no reset; clearing the pointers is what discards contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= op_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      tx_en_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      tx_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            data_out_q <= mem_q[rd_ptr_q];
            tx_en_q    <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          // Proceed without a busy acknowledgement rather than stall forever.
          if (tx_busy || tmo_q == TMO_LAST) state_q <= WAIT_DONE;
          else                              tmo_q   <= tmo_q + TW'(1);
        end
        WAIT_DONE: begin
          if (!tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_en      = tx_en_q;
  assign data_out   = data_out_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stream_data_processor.sv
// Self-checking bench for stream_data_processor: scoreboard of expected
// transmit words plus directed checks on flags, latency, timeout and reset.
module tb_stream_data_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic [1:0] mode;
  logic       tx_busy;
  logic       clr_overflow;
  logic       tx_en;
  logic [7:0] data_out;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  logic       hold_busy  = 1'b0;
  logic       model_busy = 1'b0;
  logic       auto_en    = 1'b0;
  int         busy_cnt   = 0;
  int         cyc        = 0;
  int         tx_total   = 0;
  int         n_cmp      = 0;
  int         n_err      = 0;
  logic [7:0] sb[$];

  assign tx_busy = hold_busy | model_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  stream_data_processor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .mode          (mode),
    .tx_busy       (tx_busy),
    .clr_overflow  (clr_overflow),
    .tx_en         (tx_en),
    .data_out      (data_out),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_op(input logic [1:0] m, input logic [7:0] d);
    case (m)
      2'b00:   return d + 8'd1;
      2'b01:   return d - 8'd1;
      2'b10:   return d ^ 8'd1;
      default: return d;
    endcase
  endfunction

  // Transmitter model: raises busy in the tx_en cycle and holds it three cycles.
  always @(negedge clk) begin
    if (auto_en && tx_en) busy_cnt = 3;
    else if (busy_cnt > 0) busy_cnt--;
    model_busy = (busy_cnt > 0);
  end

  // Output monitor: every tx_en pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && tx_en) begin
      tx_total++;
      if (sb.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else                check("data_out", {24'd0, data_out}, {24'd0, sb.pop_front()});
    end
  end

  // Drives one word for one cycle; called at a negedge, returns at the next.
  task automatic send(input logic [1:0] m, input logic [7:0] d, input bit expect_kept);
    rx_data_valid = 1'b1;
    rx_data       = d;
    mode          = m;
    if (expect_kept) sb.push_back(model_op(m, d));
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag, output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_en) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_drain_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    int c1, c2, tx_before;
    rst_n = 1'b0; rx_data_valid = 1'b0; rx_data = '0; mode = '0; clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en",  tx_en, 0);
    check("rst_data",   data_out, 0);
    check("rst_count",  fifo_count, 0);
    check("rst_empty",  fifo_empty, 1);
    check("rst_full",   fifo_full, 0);
    check("rst_ovf",    overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: word sampled at the first edge, tx_en visible two cycles later.
    send(2'b00, 8'h41, 1'b1);
    check("lat_no_early_tx", tx_en, 0);
    @(negedge clk);
    check("lat_tx_en", tx_en, 1);
    check("lat_empty_after", fifo_empty, 1);
    repeat (10) @(negedge clk);

    // Modes and wrap-around, transmitted in order under the busy model.
    auto_en = 1'b1;
    send(2'b00, 8'hFF, 1'b1);
    send(2'b01, 8'h00, 1'b1);
    send(2'b10, 8'h0F, 1'b1);
    send(2'b11, 8'h5A, 1'b1);
    wait_drain("modes", 200);
    repeat (5) @(negedge clk);

    // Burst under busy fills the FIFO.
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) send(2'b00, 8'(i), 1'b1);
    check("burst_count", fifo_count, 16);
    check("burst_full",  fifo_full, 1);
    check("burst_empty", fifo_empty, 0);

    // Overflow: drop sets the flag, a clear on a dropping edge loses.
    send(2'b00, 8'h99, 1'b0);
    check("ovf_set",   overflow, 1);
    check("ovf_count", fifo_count, 16);
    clr_overflow = 1'b1;
    send(2'b00, 8'h77, 1'b0);
    clr_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Release busy with a write on the same edge as the pop at full.
    hold_busy = 1'b0;
    send(2'b11, 8'h33, 1'b1);
    check("simul_count", fifo_count, 16);
    check("simul_no_ovf", overflow, 0);
    wait_drain("burst", 600);
    repeat (5) @(negedge clk);
    check("burst_empty_end", fifo_empty, 1);

    // Timeout: busy never rises, the next word still goes out 7 cycles later.
    auto_en = 1'b0;
    repeat (5) @(negedge clk);
    send(2'b00, 8'h10, 1'b1);
    wait_tx("tmo_first", c1);
    send(2'b00, 8'h20, 1'b1);
    wait_tx("tmo_second", c2);
    check("tmo_spacing", c2 - c1, 7);
    repeat (10) @(negedge clk);

    // Reset while in WAIT_DONE with five words buffered.
    send(2'b11, 8'hA5, 1'b1);
    wait_tx("rst_seq", c1);
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(2'b00, 8'hC0 + 8'(i), 1'b0);
    check("pre_rst_count", fifo_count, 5);
    check("pre_rst_data",  data_out, 8'hA5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_data",  data_out, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_full",  fifo_full, 0);
    check("mid_rst_ovf",   overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    hold_busy = 1'b0;
    tx_before = tx_total;
    repeat (20) @(negedge clk);
    check("post_rst_no_tx", tx_total, tx_before);
    check("sb_empty_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_data_processor.md
Name: stream_data_processor

Overview:
Parametrised successor to the UART byte-increment stage, sitting between the UART receiver and transmitter. It applies a run-time selectable operation (add, subtract, XOR with a constant, or pass-through) to each received word. Results are buffered in an internal FIFO so that back-to-back receptions are not lost while the transmitter is busy. Words are issued to the transmitter one at a time under a tx_busy handshake.

Parameters:
DATA_BITS, 8, width of data words.
FIFO_DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
OP_CONST, 1, operand for the add/sub/xor modes; truncated to DATA_BITS.
START_TIMEOUT, 4, cycles to wait for tx_busy to rise after a tx_en pulse; minimum 1.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
rx_data_valid  input  1  single-cycle strobe: rx_data is valid.
rx_data  input  DATA_BITS  received word.
mode  input  2  operation: 00 add, 01 sub, 10 xor, 11 pass-through; sampled on the cycle of rx_data_valid.
tx_busy  input  1  transmitter busy; high from acceptance until the frame ends.
clr_overflow  input  1  clears the sticky overflow flag.
tx_en  output  1  single-cycle transmit request.
data_out  output  DATA_BITS  word to transmit; stable from the tx_en cycle until the next pop.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
fifo_full  output  1  occupancy == FIFO_DEPTH.
fifo_empty  output  1  occupancy == 0.
overflow  output  1  sticky flag: a word was dropped.

Behaviour:
- Reset (async, rst_n low):
  - tx_en=0, data_out=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - FSM returns to IDLE; pointers cleared; FIFO contents discarded, including on reset mid-transfer.
- Operation stage (combinational on the write path):
  - add: rx_data+OP_CONST, mod 2^DATA_BITS.
  - sub: rx_data-OP_CONST, mod 2^DATA_BITS.
  - xor: rx_data^OP_CONST.
  - pass: rx_data.
  - No carry or borrow is kept; wrap-around is silent.
- Write:
  - On a clk edge with rx_data_valid=1, the result is written if not full, or if full and a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set.
- Overflow flag:
  - Held until clr_overflow=1.
  - If a set and a clear occur on the same edge, the set wins.
- Pop: occurs only in IDLE when fifo_empty=0 and tx_busy=0. On that edge, data_out is loaded with the head entry and the FSM moves to ISSUE.
- fifo_count:
  - +1 on a write only, -1 on a pop only.
  - Unchanged on a simultaneous write and pop, or when neither occurs.
  - fifo_full and fifo_empty are registered and consistent with fifo_count every cycle.
- FSM:
  - IDLE: waits for a pop condition (above), then moves to ISSUE.
  - ISSUE: tx_en=1 for exactly this cycle; next state WAIT_START; the timeout counter is cleared.
  - WAIT_START: moves to WAIT_DONE when tx_busy=1, or when the counter reaches START_TIMEOUT-1 (proceed anyway); otherwise the counter increments.
  - WAIT_DONE: moves to IDLE when tx_busy=0.
- Latency and throughput:
  - rx_data_valid on cycle N with an empty FIFO, idle FSM and tx_busy=0 gives data_out valid and tx_en=1 on cycle N+2.
  - Minimum spacing between tx_en pulses is 3 cycles plus the tx_busy duration.
- tx_en is never asserted outside ISSUE; at most one pulse per popped word.
- A mode change takes effect only for subsequent writes; already-buffered words are unaffected.

Test Plan:
- Reset then single word: mode=00, rx_data=0x41 on cycle N, tx_busy=0 -> tx_en pulse on cycle N+2 with data_out=0x42; fifo_empty=1 afterwards.
- Wrap and modes: 0xFF with add -> 0x00; 0x00 with sub -> 0xFF; 0x0F with xor -> 0x0E; 0x5A with pass -> 0x5A; all transmitted in order.
- Burst under busy: hold tx_busy=1, write 16 words 0x00..0x0F (add), then release tx_busy -> fifo_full=1 and fifo_count=16 before release; then 16 tx_en pulses with data_out 0x01..0x10 in order, each waiting for tx_busy to fall.
- Overflow: fill 16 entries, write a 17th (0x99) while tx_busy=1 -> 0x99 dropped, overflow=1, fifo_count stays 16; clr_overflow together with another dropped write -> overflow stays 1; clr_overflow alone -> overflow=0.
- Simultaneous write/pop at full, and timeout: while full, a pop and write coincide -> count stays 16 and the new word appears last; tx_busy never rises after tx_en -> FSM leaves WAIT_START after 4 cycles and the next tx_en occurs without a hang.
- Reset mid-operation: assert rst_n=0 in WAIT_DONE with 5 words buffered -> all outputs take their reset values immediately, and no tx_en occurs after release until new rx_data_valid.
